// File: rtl/traffic_ctrl_param.sv
// Highway/city intersection controller. The highway rests on green until city
// traffic or a pedestrian asks for a turn. Emergency holds or returns right of way to the highway.
module traffic_ctrl_param #(
  parameter int CAR_W          = 3,
  parameter int CNT_W          = 4,
  parameter int HWY_MIN_GREEN  = 8,
  parameter int CITY_GREEN_CYC = 11,
  parameter int YELLOW_CYC     = 3,
  parameter int ALLRED_CYC     = 1,
  parameter int CAR_THRESH     = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CAR_W-1:0] carCount,
  input  logic             ped_req,
  input  logic             emergency,
  output logic [1:0]       Highway,
  output logic [1:0]       Cityroad,
  output logic             ped_walk,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    HG_CR = 3'd0,
    HY_CR = 3'd1,
    AR1   = 3'd2,
    HR_CG = 3'd3,
    HR_CY = 3'd4,
    AR2   = 3'd5
  } state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  // Dwell limits are the last timer value spent in a state.
  localparam logic [CNT_W-1:0] HG_LIM = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] CG_LIM = CNT_W'(CITY_GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LIM  = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] AR_LIM = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CAR_W:0]   THR    = (CAR_W+1)'(CAR_THRESH);

  state_t           state, nxt;
  logic [CNT_W-1:0] timer;
  logic             ped_pending;
  logic             city_wants;

  assign city_wants = ({1'b0, carCount} >= THR) || ped_pending;
  assign state_o    = state;

  always_comb begin
    nxt = state;
    case (state)
      HG_CR: if (timer >= HG_LIM && !emergency && city_wants) nxt = HY_CR;
      HY_CR: if (timer == Y_LIM)  nxt = AR1;
      AR1:   if (timer == AR_LIM) nxt = HR_CG;
      HR_CG: if (timer == CG_LIM || emergency) nxt = HR_CY;
      HR_CY: if (timer == Y_LIM)  nxt = AR2;
      AR2:   if (timer == AR_LIM) nxt = HG_CR;
      default: nxt = HG_CR;
    endcase
  end

  // Lamps are registered from the next state so they always match state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= HG_CR;
      timer       <= '0;
      ped_pending <= 1'b0;
      Highway     <= GREEN;
      Cityroad    <= RED;
      ped_walk    <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)    timer <= '0;
      else if (timer != '1) timer <= timer + 1'b1;
      if (nxt == HR_CG)    ped_pending <= 1'b0;
      else if (ped_req)    ped_pending <= 1'b1;
      case (nxt)
        HY_CR:     begin Highway <= YELLOW; Cityroad <= RED;    end
        AR1, AR2:  begin Highway <= RED;    Cityroad <= RED;    end
        HR_CG:     begin Highway <= RED;    Cityroad <= GREEN;  end
        HR_CY:     begin Highway <= RED;    Cityroad <= YELLOW; end
        default:   begin Highway <= GREEN;  Cityroad <= RED;    end
      endcase
      ped_walk <= (nxt == HR_CG);
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: default instance plus a parameter-sweep instance,
// both tracked every cycle by a phase-ring reference model.
module tb_traffic_ctrl_param;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] carCount;
  logic       ped_req, emergency;
  logic [1:0] hw[2], cr[2];
  logic       walk[2];
  logic [2:0] st[2];

  traffic_ctrl_param dut (
    .clock(clock), .reset(reset), .carCount(carCount), .ped_req(ped_req),
    .emergency(emergency), .Highway(hw[0]), .Cityroad(cr[0]),
    .ped_walk(walk[0]), .state_o(st[0])
  );

  traffic_ctrl_param #(.CNT_W(5), .YELLOW_CYC(1), .ALLRED_CYC(2), .CITY_GREEN_CYC(20)) dut2 (
    .clock(clock), .reset(reset), .carCount(carCount), .ped_req(ped_req),
    .emergency(emergency), .Highway(hw[1]), .Cityroad(cr[1]),
    .ped_walk(walk[1]), .state_o(st[1])
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: six phases in a ring, each with a dwell length; phase 0 waits for demand.
  int m_st[2], m_el[2], tmax[2];
  bit m_pp[2];
  int dur[2][6];

  typedef struct {
    bit       rst;
    logic [2:0] car;
    bit       ped, em;
    int       n;
    int       exp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int hw_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 1 : 0;
  endfunction

  function automatic int cr_of(input int s);
    return (s == 3) ? 2 : (s == 4) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin m_st[k] = 0; m_el[k] = 0; m_pp[k] = 0; end
  endtask

  task automatic model_step();
    int nxt;
    for (int k = 0; k < 2; k++) begin
      nxt = m_st[k];
      if (m_st[k] == 0) begin
        if (m_el[k] >= dur[k][0] - 1 && !emergency && (int'(carCount) >= 5 || m_pp[k]))
          nxt = 1;
      end else if ((m_st[k] == 3 && emergency) || m_el[k] + 1 >= dur[k][m_st[k]]) begin
        nxt = (m_st[k] + 1) % 6;
      end
      m_el[k] = (nxt != m_st[k]) ? 0 : ((m_el[k] < tmax[k]) ? m_el[k] + 1 : tmax[k]);
      if (nxt == 3) m_pp[k] = 0;
      else if (ped_req) m_pp[k] = 1;
      m_st[k] = nxt;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("state%0d", k), int'(st[k]), m_st[k]);
      chk($sformatf("highway%0d", k), int'(hw[k]), hw_of(m_st[k]));
      chk($sformatf("cityroad%0d", k), int'(cr[k]), cr_of(m_st[k]));
      chk($sformatf("ped_walk%0d", k), int'(walk[k]), (m_st[k] == 3) ? 1 : 0);
      chk($sformatf("safety%0d", k),
          int'((hw[k] != 2'b10 || cr[k] != 2'b10) && (hw[k] == 2'b00 || cr[k] == 2'b00)), 1);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  // Assert reset mid-cycle, check outputs before any edge, release #1 after an edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_highway", int'(hw[0]), 2);
    chk("rst_cityroad", int'(cr[0]), 0);
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  task automatic add(input bit r, input int car, input bit p, input bit e, input int n, input int x);
    vec_t v;
    v.rst = r; v.car = 3'(car); v.ped = p; v.em = e; v.n = n; v.exp = x;
    tbl.push_back(v);
  endtask

  int exp_dw[2][6];
  int n;

  initial begin
    dur[0] = '{8, 3, 1, 11, 3, 1};
    dur[1] = '{8, 1, 2, 20, 1, 2};
    tmax[0] = 15; tmax[1] = 31;
    exp_dw[0] = '{8, 3, 1, 11, 3, 1};
    exp_dw[1] = '{8, 1, 2, 20, 1, 2};

    // Full cycle, then below-threshold hold
    add(1, 5, 0, 0, 7, 0); add(0, 5, 0, 0, 3, 1); add(0, 5, 0, 0, 1, 2);
    add(0, 5, 0, 0, 11, 3); add(0, 5, 0, 0, 3, 4); add(0, 5, 0, 0, 1, 5);
    add(0, 5, 0, 0, 1, 0); add(0, 4, 0, 0, 100, 0);
    // Single-cycle pedestrian request, then pending must be gone
    add(1, 0, 0, 0, 2, 0); add(0, 0, 1, 0, 1, 0); add(0, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0, 3, 1); add(0, 0, 0, 0, 1, 2); add(0, 0, 0, 0, 11, 3);
    add(0, 0, 0, 0, 3, 4); add(0, 0, 0, 0, 1, 5); add(0, 0, 0, 0, 30, 0);
    // Emergency at HR_CG timer 4, then highway hold under emergency
    add(1, 5, 0, 0, 7, 0); add(0, 5, 0, 0, 3, 1); add(0, 5, 0, 0, 1, 2);
    add(0, 5, 0, 0, 5, 3); add(0, 7, 0, 1, 3, 4); add(0, 7, 0, 1, 1, 5);
    add(0, 7, 0, 1, 20, 0); add(0, 7, 0, 0, 1, 1);
    // Emergency during AR1 still enters HR_CG, leaves on the next edge
    add(1, 5, 0, 0, 7, 0); add(0, 5, 0, 0, 3, 1); add(0, 5, 0, 0, 1, 2);
    add(0, 5, 0, 1, 1, 3); add(0, 5, 0, 1, 1, 4);

    carCount = '0; ped_req = 1'b0; emergency = 1'b0;
    do_reset();

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        carCount = '0; ped_req = 1'b0; emergency = 1'b0;
        do_reset();
      end
      carCount = tbl[i].car; ped_req = tbl[i].ped; emergency = tbl[i].em;
      repeat (tbl[i].n) begin
        cycle();
        chk($sformatf("tbl%0d_state", i), int'(st[0]), tbl[i].exp);
      end
    end
    ped_req = 1'b0; emergency = 1'b0;

    // Async reset from HR_CY; timer must restart so HG lasts the full minimum
    carCount = 3'd5;
    do_reset();
    repeat (23) cycle();
    chk("pre_async_state", int'(st[0]), 4);
    do_reset();
    repeat (7) cycle();
    chk("post_async_hg", int'(st[0]), 0);
    cycle();
    chk("post_async_hy", int'(st[0]), 1);

    // Dwell length of every phase on both instances
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int s = 0; s < 6; s++) begin
        n = 0;
        while (int'(st[k]) == s && n < 64) begin cycle(); n++; end
        chk($sformatf("dwell%0d_s%0d", k, s), n, exp_dw[k][s]);
      end
    end

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      carCount  = 3'($urandom_range(0, 7));
      ped_req   = ($urandom_range(0, 9) == 0);
      emergency = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
